pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline stage register, the successor to our fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries one payload word and one control word, split in two so control can be killed independently. It uses a valid/ready handshake in place of a bare stall. It adds:
- optional 2-entry skid buffering, so ready is registered;
- synchronous flush;
- control zeroing on bubbles;
- a saturating count of squashed entries for hazard/branch debug.

Parameters:
DATA_W, 64, payload width in bits (immediates, register data, addresses).
CTRL_W, 8, control-bit width (RegWrite, MemRead, ALUOp, ...); forced to 0 whenever the output is not valid.
SKID, 1, 1 = two entries (main + skid) with registered in_ready_o; 0 = single entry with combinational in_ready_o.
CNT_W, 8, width of the flush counter.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous reset, active-high.
in_valid_i  in  1  upstream presents an entry.
in_ready_o  out  1  stage accepts an entry this cycle.
in_ctrl_i  in  CTRL_W  upstream control word.
in_data_i  in  DATA_W  upstream payload.
out_valid_o  out  1  stage presents an entry downstream.
out_ready_i  in  1  downstream accepts an entry.
out_ctrl_o  out  CTRL_W  control word; 0 when out_valid_o=0.
out_data_o  out  DATA_W  payload; holds its last value when not valid.
stall_i  in  1  freeze: no transfer in or out this cycle.
flush_i  in  1  squash every held entry and any incoming entry.
occupancy_o  out  2  entries held (0..1 when SKID=0, 0..2 when SKID=1).
flush_cnt_o  out  CNT_W  valid entries squashed since reset, saturating.

Behaviour:
- Reset (rst_i=1 at an edge):
  - all valid bits 0; ctrl and data registers 0; flush_cnt_o=0.
  - After reset: out_valid_o=0, out_ctrl_o=0, out_data_o=0, occupancy_o=0, in_ready_o=1 (when stall_i=0).
  - Reset overrides flush, stall and all handshakes, including mid-transfer.
- Handshakes:
  - Input transfer: in_valid_i & in_ready_o. Output transfer: out_valid_o & out_ready_i.
  - Latency: an accepted entry appears at out_* on the next cycle when the stage was empty (1-cycle latency).
  - Order is strictly FIFO.
- SKID=0:
  - in_ready_o = !stall_i & (!main_v | out_ready_i). Same-cycle drain and refill is allowed.
- SKID=1:
  - in_ready_o = !stall_i & !skid_v, where skid_v is a register.
  - An input arriving while main is full and not draining goes to skid.
  - When main drains, skid moves to main in the same edge. If an input is also accepted in that edge, it goes to skid.
  - Full (occupancy 2): in_ready_o=0. Input is never lost, and the payload is never duplicated.
- stall_i=1:
  - in_ready_o=0 and out_valid_o=0 (so out_ctrl_o=0); no state change.
  - Contents reappear unchanged when stall_i drops.
- flush_i=1 (priority over stall and handshakes, below reset):
  - Next edge: all valid bits cleared and ctrl registers cleared. An input handshaking in the same cycle is discarded.
  - out_valid_o is unaffected in the flush cycle itself (combinational view of current state). Downstream must not treat a same-cycle output transfer as squashed; that transfer completes.
  - flush_cnt_o += number of valid entries held at the edge (0..2), excluding one completing an output transfer that cycle. Saturates at 2^CNT_W-1 and never wraps.
- Bubble rule: out_ctrl_o = out_valid_o ? ctrl_reg : 0 at all times.
- occupancy_o = main_v + skid_v.
- Widths: DATA_W and CTRL_W ≥ 1. When SKID=0 the skid logic is absent and occupancy_o[1]=0.

Test Plan:
- Reset then stream, SKID=1, out_ready_i=1: inputs data 0x11,0x22,0x33 ctrl 0x81 on consecutive cycles -> outputs appear 1 cycle later, back to back, occupancy_o=1, in_ready_o stays 1.
- Backpressure, SKID=1: hold out_ready_i=0 and drive 3 entries -> first two accepted (occupancy 2), in_ready_o=0 before the third. Release -> output order 0x11,0x22 then 0x33; no loss, no duplication.
- Stall: with 1 entry held (ctrl 0x05), stall_i=1 for 3 cycles -> out_valid_o=0, out_ctrl_o=0, in_ready_o=0. Release -> entry 0x05 presented unchanged.
- Flush with 2 entries held plus an input: flush_i=1 for 1 cycle -> next cycle occupancy_o=0, out_ctrl_o=0, flush_cnt_o=2. Incoming entry never emerges.
- Saturation, CNT_W=2: 5 flushes of 1 entry each -> flush_cnt_o reads 1,2,3,3,3.
- SKID=0 same-cycle drain/refill with out_ready_i=1: in_ready_o=1 while full; mid-stream rst_i=1 -> next cycle all outputs 0, then normal operation resumes.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline stage with optional skid entry, flush and squash counter
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);
  logic              main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    cnt_sum;
  logic [1:0]        flushed;
  logic              in_fire, out_fire, main_take, main_from_skid, main_from_in, skid_load;
  assign in_ready_o  = !stall_i & ((SKID != 0) ? !skid_v_q : (!main_v_q | out_ready_i));
  assign out_valid_o = main_v_q & !stall_i;
  assign out_ctrl_o  = out_valid_o ? main_ctrl_q : '0;
  assign out_data_o  = main_data_q;
  assign occupancy_o = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign flush_cnt_o = cnt_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  // next state: main refills from skid first (FIFO order), else from input; flush kills valids and ctrl
  always_comb begin
    main_take      = !main_v_q | out_fire;
    main_from_skid = !flush_i & main_take & skid_v_q;
    main_from_in   = !flush_i & main_take & !skid_v_q & in_fire;
    skid_load      = (SKID != 0) & !flush_i & !main_take & in_fire;
    main_v_d       = flush_i ? 1'b0 : main_take ? (skid_v_q | in_fire) : 1'b1;
    main_ctrl_d    = flush_i ? '0 : main_from_skid ? skid_ctrl_q : main_from_in ? in_ctrl_i : main_ctrl_q;
    main_data_d    = main_from_skid ? skid_data_q : main_from_in ? in_data_i : main_data_q;
    skid_v_d       = (SKID != 0) & !flush_i & !main_take & (skid_v_q | in_fire);
    skid_ctrl_d    = flush_i ? '0 : skid_load ? in_ctrl_i : skid_ctrl_q;
    skid_data_d    = skid_load ? in_data_i : skid_data_q;
    flushed        = 2'(main_v_q & !out_fire) + 2'(skid_v_q);
    cnt_sum        = {1'b0, cnt_q} + (CNT_W+1)'(flushed);
    cnt_d          = !flush_i ? cnt_q : cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end
  // state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      main_data_q <= '0;
      skid_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_ctrl_q <= main_ctrl_d;
      skid_ctrl_q <= skid_ctrl_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: table-driven check of the skid stage plus a hand sequence for the single-entry stage
module tb_pipe_stage_reg;
  logic clk = 0, rst = 1, iv = 0, ordy = 0, st = 0, fl = 0;
  logic [7:0] ctrl = 0;
  logic [63:0] data = 0;
  logic a_irdy, a_ov, b_irdy, b_ov;
  logic [7:0] a_ctrl, b_ctrl;
  logic [63:0] a_data, b_data;
  logic [1:0] a_occ, b_occ, a_cnt;
  logic [7:0] b_cnt;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1), .CNT_W(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv), .in_ready_o(a_irdy), .in_ctrl_i(ctrl), .in_data_i(data),
    .out_valid_o(a_ov), .out_ready_i(ordy), .out_ctrl_o(a_ctrl), .out_data_o(a_data),
    .stall_i(st), .flush_i(fl), .occupancy_o(a_occ), .flush_cnt_o(a_cnt));
  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0), .CNT_W(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv), .in_ready_o(b_irdy), .in_ctrl_i(ctrl), .in_data_i(data),
    .out_valid_o(b_ov), .out_ready_i(ordy), .out_ctrl_o(b_ctrl), .out_data_o(b_data),
    .stall_i(st), .flush_i(fl), .occupancy_o(b_occ), .flush_cnt_o(b_cnt));
  typedef struct {
    logic rst, iv; logic [7:0] c; logic [63:0] d; logic ordy, st, fl;
    logic e_irdy, e_ov; logic [7:0] e_c; logic [63:0] e_d; logic [1:0] e_occ, e_cnt;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(input logic r, v, input logic [7:0] c, input logic [63:0] d,
                              input logic o, s, f, ei, eo, input logic [7:0] ec, input logic [63:0] ed,
                              input logic [1:0] eoc, ecn);
    vec_t t;
    t.rst = r; t.iv = v; t.c = c; t.d = d; t.ordy = o; t.st = s; t.fl = f;
    t.e_irdy = ei; t.e_ov = eo; t.e_c = ec; t.e_d = ed; t.e_occ = eoc; t.e_cnt = ecn;
    return t;
  endfunction
  task automatic chk(input string n, input logic [63:0] act, exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", n, act, exp);
    else passed++;
  endtask
  task automatic drive(input logic r, v, input logic [7:0] c, input logic [63:0] d, input logic o, s, f);
    @(negedge clk);
    rst = r; iv = v; ctrl = c; data = d; ordy = o; st = s; fl = f;
    #1;
  endtask
  initial begin
    tv.push_back(mk(0,0,8'h00,64'h00,1,0,0, 1,0,8'h00,64'h00,0,0));
    tv.push_back(mk(0,1,8'h81,64'h11,1,0,0, 1,0,8'h00,64'h00,0,0));
    tv.push_back(mk(0,1,8'h81,64'h22,1,0,0, 1,1,8'h81,64'h11,1,0));
    tv.push_back(mk(0,1,8'h81,64'h33,1,0,0, 1,1,8'h81,64'h22,1,0));
    tv.push_back(mk(0,0,8'h00,64'h00,1,0,0, 1,1,8'h81,64'h33,1,0));
    tv.push_back(mk(0,0,8'h00,64'h00,0,0,0, 1,0,8'h00,64'h33,0,0));
    tv.push_back(mk(0,1,8'h42,64'h11,0,0,0, 1,0,8'h00,64'h33,0,0));
    tv.push_back(mk(0,1,8'h42,64'h22,0,0,0, 1,1,8'h42,64'h11,1,0));
    tv.push_back(mk(0,1,8'h42,64'h33,0,0,0, 0,1,8'h42,64'h11,2,0));
    tv.push_back(mk(0,1,8'h42,64'h33,1,0,0, 0,1,8'h42,64'h11,2,0));
    tv.push_back(mk(0,1,8'h42,64'h33,1,0,0, 1,1,8'h42,64'h22,1,0));
    tv.push_back(mk(0,0,8'h00,64'h00,1,0,0, 1,1,8'h42,64'h33,1,0));
    tv.push_back(mk(0,0,8'h00,64'h00,1,0,0, 1,0,8'h00,64'h33,0,0));
    tv.push_back(mk(0,1,8'h05,64'h55,0,0,0, 1,0,8'h00,64'h33,0,0));
    for (int k = 0; k < 3; k++) tv.push_back(mk(0,1,8'h09,64'h99,1,1,0, 0,0,8'h00,64'h55,1,0));
    tv.push_back(mk(0,0,8'h00,64'h00,0,0,0, 1,1,8'h05,64'h55,1,0));
    tv.push_back(mk(0,1,8'h0a,64'h66,0,0,0, 1,1,8'h05,64'h55,1,0));
    tv.push_back(mk(0,1,8'h0b,64'h77,0,0,1, 0,1,8'h05,64'h55,2,0));
    tv.push_back(mk(0,0,8'h00,64'h00,1,0,0, 1,0,8'h00,64'h55,0,2));
    tv.push_back(mk(0,1,8'h0b,64'h77,1,0,1, 1,0,8'h00,64'h55,0,2));
    tv.push_back(mk(0,0,8'h00,64'h00,1,0,0, 1,0,8'h00,64'h55,0,2));
    tv.push_back(mk(0,1,8'h0c,64'h88,0,0,0, 1,0,8'h00,64'h55,0,2));
    tv.push_back(mk(0,0,8'h00,64'h00,1,0,1, 1,1,8'h0c,64'h88,1,2));
    tv.push_back(mk(0,0,8'h00,64'h00,1,0,0, 1,0,8'h00,64'h88,0,2));
    tv.push_back(mk(1,1,8'h0d,64'h99,1,0,0, 1,0,8'h00,64'h88,0,2));
    tv.push_back(mk(0,1,8'h01,64'ha1,0,0,0, 1,0,8'h00,64'h00,0,0));
    tv.push_back(mk(0,0,8'h00,64'h00,0,0,1, 1,1,8'h01,64'ha1,1,0));
    tv.push_back(mk(0,1,8'h01,64'ha2,0,0,0, 1,0,8'h00,64'ha1,0,1));
    tv.push_back(mk(0,0,8'h00,64'h00,0,0,1, 1,1,8'h01,64'ha2,1,1));
    tv.push_back(mk(0,1,8'h01,64'ha3,0,0,0, 1,0,8'h00,64'ha2,0,2));
    tv.push_back(mk(0,0,8'h00,64'h00,0,0,1, 1,1,8'h01,64'ha3,1,2));
    tv.push_back(mk(0,1,8'h01,64'ha4,0,0,0, 1,0,8'h00,64'ha3,0,3));
    tv.push_back(mk(0,0,8'h00,64'h00,0,0,1, 1,1,8'h01,64'ha4,1,3));
    tv.push_back(mk(0,1,8'h01,64'ha5,0,0,0, 1,0,8'h00,64'ha4,0,3));
    tv.push_back(mk(0,0,8'h00,64'h00,0,0,1, 1,1,8'h01,64'ha5,1,3));
    tv.push_back(mk(0,0,8'h00,64'h00,0,0,0, 1,0,8'h00,64'ha5,0,3));
    drive(1,0,0,0,0,0,0);
    drive(1,0,0,0,0,0,0);
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].iv, tv[i].c, tv[i].d, tv[i].ordy, tv[i].st, tv[i].fl);
      chk($sformatf("v%0d in_ready", i), 64'(a_irdy), 64'(tv[i].e_irdy));
      chk($sformatf("v%0d out_valid", i), 64'(a_ov), 64'(tv[i].e_ov));
      chk($sformatf("v%0d out_ctrl", i), 64'(a_ctrl), 64'(tv[i].e_c));
      chk($sformatf("v%0d out_data", i), a_data, tv[i].e_d);
      chk($sformatf("v%0d occupancy", i), 64'(a_occ), 64'(tv[i].e_occ));
      chk($sformatf("v%0d flush_cnt", i), 64'(a_cnt), 64'(tv[i].e_cnt));
    end
    drive(1,0,0,0,0,0,0);
    drive(0,0,0,0,1,0,0);
    chk("b reset in_ready", 64'(b_irdy), 64'd1);
    chk("b reset out_valid", 64'(b_ov), 64'd0);
    chk("b reset occupancy", 64'(b_occ), 64'd0);
    chk("b reset data", b_data, 64'd0);
    drive(0,1,8'h81,64'h31,1,0,0);
    chk("b accept empty", 64'(b_irdy), 64'd1);
    drive(0,1,8'h81,64'h32,1,0,0);
    chk("b ready full draining", 64'(b_irdy), 64'd1);
    chk("b out 31", b_data, 64'h31);
    chk("b ctrl 81", 64'(b_ctrl), 64'h81);
    chk("b occ 1", 64'(b_occ), 64'd1);
    drive(0,1,8'h81,64'h33,0,0,0);
    chk("b ready full blocked", 64'(b_irdy), 64'd0);
    chk("b out 32", b_data, 64'h32);
    drive(0,1,8'h81,64'h33,1,0,0);
    chk("b hold 32", b_data, 64'h32);
    chk("b ready again", 64'(b_irdy), 64'd1);
    drive(1,1,8'h81,64'h34,1,0,0);
    chk("b out 33 before reset", b_data, 64'h33);
    chk("b valid before reset", 64'(b_ov), 64'd1);
    drive(0,0,0,0,1,0,0);
    chk("b post reset valid", 64'(b_ov), 64'd0);
    chk("b post reset ctrl", 64'(b_ctrl), 64'd0);
    chk("b post reset data", b_data, 64'd0);
    chk("b post reset occ", 64'(b_occ), 64'd0);
    chk("b post reset cnt", 64'(b_cnt), 64'd0);
    chk("b post reset ready", 64'(b_irdy), 64'd1);
    drive(0,1,8'h81,64'h35,1,0,0);
    drive(0,0,0,0,1,0,0);
    chk("b resume valid", 64'(b_ov), 64'd1);
    chk("b resume data", b_data, 64'h35);
    chk("b resume ctrl", 64'(b_ctrl), 64'h81);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
